// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control inputs, program memory port and the decoder-facing
// instruction output, bundled for the instruction_fetch block.
//
// Flow semantics: Stall=1 means the downstream stage is not ready; the fetch
// stage then freezes completely and drops PM_RE. When Stall=0, the word on
// Ins is consumed on every rising edge; Ins_Valid=0 marks a bubble and always
// comes with Ins equal to the NOP word. PM_Data is the memory word for the
// address presented with PM_RE=1 in the previous cycle.
interface instruction_fetch_if #(
    parameter int PC_WIDTH  = 8,
    parameter int INS_WIDTH = 13
);
    logic                 Start;
    logic                 Stall;
    logic                 Jump;
    logic [PC_WIDTH-1:0]  JumpAddr;
    logic [PC_WIDTH-1:0]  PM_Addr;
    logic                 PM_RE;
    logic [INS_WIDTH-1:0] PM_Data;
    logic [INS_WIDTH-1:0] Ins;
    logic                 Ins_Valid;
    logic [PC_WIDTH-1:0]  Ins_PC;
    logic                 Halted;

    // Fetch stage side
    modport master (
        input  Start, Stall, Jump, JumpAddr, PM_Data,
        output PM_Addr, PM_RE, Ins, Ins_Valid, Ins_PC, Halted
    );

    // Environment side (control, program memory and decoder)
    modport slave (
        output Start, Stall, Jump, JumpAddr, PM_Data,
        input  PM_Addr, PM_RE, Ins, Ins_Valid, Ins_PC, Halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, drives a 1-cycle-latency program
// memory, registers the returned word for the decoder, and handles start,
// stall, jump redirect and HALT detection. Bubbles are presented as NOP_INS.
module instruction_fetch #(
    parameter int                   PC_WIDTH     = 8,
    parameter int                   INS_WIDTH    = 13,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [INS_WIDTH-1:0] NOP_INS      = 13'h1F00,
    parameter logic [4:0]           HALT_OPCODE  = 5'b11110
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state;
    logic [PC_WIDTH-1:0]  pc;
    logic                 pend_valid;   // a read was issued last cycle and is still wanted
    logic [PC_WIDTH-1:0]  pend_pc;      // address of that read
    logic [INS_WIDTH-1:0] ins_q;
    logic                 ins_valid_q;
    logic [PC_WIDTH-1:0]  ins_pc_q;
    logic                 halted_q;
    logic                 halt_capture;
    logic                 take_word;

    // A HALT word returning for a live read stops fetch, unless a jump
    // on the same edge makes that word wrong-path.
    assign halt_capture = pend_valid & ~bus.Jump &
                          (bus.PM_Data[INS_WIDTH-1 -: 5] == HALT_OPCODE);
    assign take_word    = pend_valid & ~bus.Jump;

    assign bus.PM_Addr   = pc;
    assign bus.PM_RE     = (state == RUN) & ~bus.Stall;
    assign bus.Ins       = ins_q;
    assign bus.Ins_Valid = ins_valid_q;
    assign bus.Ins_PC    = ins_pc_q;
    assign bus.Halted    = halted_q;
    assign state_dbg     = state;

    // Fetch FSM, PC / pending-read tracking and registered decoder outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            ins_q       <= NOP_INS;
            ins_valid_q <= 1'b0;
            ins_pc_q    <= '0;
            halted_q    <= 1'b0;
        end else if (!bus.Stall) begin
            case (state)
                IDLE: begin
                    if (bus.Start) state <= RUN;
                end
                HALTED: begin
                    if (bus.Start) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt_capture) begin
                        // pc already points one past the HALT word: resume there
                        state       <= HALTED;
                        halted_q    <= 1'b1;
                        ins_q       <= NOP_INS;
                        ins_valid_q <= 1'b0;
                        ins_pc_q    <= pend_pc;
                        pend_valid  <= 1'b0;
                    end else begin
                        ins_q       <= take_word ? bus.PM_Data : NOP_INS;
                        ins_valid_q <= take_word;
                        ins_pc_q    <= pend_pc;
                        pend_pc     <= pc;
                        pend_valid  <= ~bus.Jump;
                        pc          <= bus.Jump ? bus.JumpAddr : pc + PC_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: start latency, jump bubbles,
// jump-over-halt, stall freeze, halt/resume, async reset and PC wrap.
module tb_instruction_fetch;

    localparam int PW = 8;
    localparam int IW = 13;
    localparam logic [IW-1:0] NOP  = 13'h1F00;
    localparam logic [IW-1:0] HALT = 13'h1E00;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [IW-1:0] mem [0:255];
    logic [IW-1:0] pm_q_a;
    logic [IW-1:0] pm_q_b;
    logic [1:0]    state_a;
    logic [1:0]    state_b;

    instruction_fetch_if #(.PC_WIDTH(PW), .INS_WIDTH(IW)) bus_a ();
    instruction_fetch_if #(.PC_WIDTH(PW), .INS_WIDTH(IW)) bus_b ();

    instruction_fetch #(.PC_WIDTH(PW), .INS_WIDTH(IW), .RESET_VECTOR(8'h00))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.master), .state_dbg(state_a));

    instruction_fetch #(.PC_WIDTH(PW), .INS_WIDTH(IW), .RESET_VECTOR(8'hFE))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master), .state_dbg(state_b));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- synchronous-read program memories ----------------
    always @(posedge clk) if (bus_a.PM_RE) pm_q_a <= mem[bus_a.PM_Addr];
    always @(posedge clk) if (bus_b.PM_RE) pm_q_b <= mem[bus_b.PM_Addr];
    assign bus_a.PM_Data = pm_q_a;
    assign bus_b.PM_Data = pm_q_b;

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ins(input string tag, input logic [IW-1:0] ins,
                           input logic vld, input logic [PW-1:0] pc);
        chk({tag, ".ins"},   16'(bus_a.Ins),       16'(ins));
        chk({tag, ".valid"}, 16'(bus_a.Ins_Valid), 16'(vld));
        chk({tag, ".pc"},    16'(bus_a.Ins_PC),    16'(pc));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_a();
        bus_a.Start = 1'b1;
        step();
        bus_a.Start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        pm_q_a   = '0;
        pm_q_b   = '0;
        for (int i = 0; i < 256; i++) mem[i] = 13'h0100 | 13'(i);
        mem[0]    = 13'h0805;
        mem[1]    = 13'h0A01;
        mem[2]    = 13'h1003;
        mem[3]    = 13'h0C07;
        mem[7]    = HALT;
        mem[8'h42] = HALT;

        bus_a.Start = 0; bus_a.Stall = 0; bus_a.Jump = 0; bus_a.JumpAddr = '0;
        bus_b.Start = 0; bus_b.Stall = 0; bus_b.Jump = 0; bus_b.JumpAddr = '0;
        rst_n = 1'b0;
        #12;

        // Phase 1: reset values and start latency
        chk_ins("rst", NOP, 1'b0, 8'h00);
        chk("rst.halted", 16'(bus_a.Halted),  16'h0);
        chk("rst.addr",   16'(bus_a.PM_Addr), 16'h00);
        chk("rst.re",     16'(bus_a.PM_RE),   16'h0);
        chk("rst.addr_b", 16'(bus_b.PM_Addr), 16'h00FE);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle.re", 16'(bus_a.PM_RE), 16'h0);
        start_a();                                   // E0
        chk("e0.addr", 16'(bus_a.PM_Addr), 16'h00);
        chk("e0.re",   16'(bus_a.PM_RE),   16'h1);
        chk("e0.valid", 16'(bus_a.Ins_Valid), 16'h0);
        step();                                      // E1
        chk("e1.addr", 16'(bus_a.PM_Addr), 16'h01);
        chk("e1.valid", 16'(bus_a.Ins_Valid), 16'h0);
        step();                                      // E2
        chk_ins("s0", 13'h0805, 1'b1, 8'h00);
        chk("s0.addr", 16'(bus_a.PM_Addr), 16'h02);
        step();
        chk_ins("s1", 13'h0A01, 1'b1, 8'h01);
        chk("s1.addr", 16'(bus_a.PM_Addr), 16'h03);
        step();
        chk_ins("s2", 13'h1003, 1'b1, 8'h02);
        step();
        chk_ins("s3", 13'h0C07, 1'b1, 8'h03);
        chk("s3.addr", 16'(bus_a.PM_Addr), 16'h05);

        // Phase 2: jump ignored in IDLE, jump bubbles, jump over a HALT word
        do_reset();
        bus_a.Jump = 1'b1; bus_a.JumpAddr = 8'h33;
        step();
        bus_a.Jump = 1'b0;
        chk("idle_jump.addr", 16'(bus_a.PM_Addr), 16'h00);
        start_a();
        step();
        step();
        chk_ins("j.s0", 13'h0805, 1'b1, 8'h00);
        step();
        step();
        chk_ins("j.s2", 13'h1003, 1'b1, 8'h02);
        bus_a.Jump = 1'b1; bus_a.JumpAddr = 8'h40;
        step();
        bus_a.Jump = 1'b0;
        chk("j.b1.ins",   16'(bus_a.Ins),       16'(NOP));
        chk("j.b1.valid", 16'(bus_a.Ins_Valid), 16'h0);
        chk("j.b1.addr",  16'(bus_a.PM_Addr),   16'h40);
        step();
        chk("j.b2.ins",   16'(bus_a.Ins),       16'(NOP));
        chk("j.b2.valid", 16'(bus_a.Ins_Valid), 16'h0);
        step();
        chk_ins("j.t0", 13'h0140, 1'b1, 8'h40);
        step();
        chk_ins("j.t1", 13'h0141, 1'b1, 8'h41);
        // word for 0x42 (HALT) is on PM_Data now; jump on this edge wins
        bus_a.Jump = 1'b1; bus_a.JumpAddr = 8'h10;
        step();
        bus_a.Jump = 1'b0;
        chk("jh.b1.valid",  16'(bus_a.Ins_Valid), 16'h0);
        chk("jh.b1.halted", 16'(bus_a.Halted),    16'h0);
        step();
        chk("jh.b2.valid",  16'(bus_a.Ins_Valid), 16'h0);
        chk("jh.b2.halted", 16'(bus_a.Halted),    16'h0);
        step();
        chk_ins("jh.t0", 13'h0110, 1'b1, 8'h10);
        step();
        chk_ins("jh.t1", 13'h0111, 1'b1, 8'h11);

        // Phase 3: stall freeze, halt capture, resume
        do_reset();
        start_a();
        step();
        for (int i = 0; i < 6; i++) step();
        chk_ins("st.pre", 13'h0105, 1'b1, 8'h05);
        bus_a.Stall = 1'b1;
        #1;
        chk("st.re_comb", 16'(bus_a.PM_RE), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ins("st.hold", 13'h0105, 1'b1, 8'h05);
            chk("st.addr", 16'(bus_a.PM_Addr), 16'h07);
            chk("st.re",   16'(bus_a.PM_RE),   16'h0);
        end
        bus_a.Stall = 1'b0;
        step();
        chk_ins("st.post", 13'h0106, 1'b1, 8'h06);
        step();
        chk_ins("h.cap", NOP, 1'b0, 8'h07);
        chk("h.halted", 16'(bus_a.Halted),  16'h1);
        chk("h.addr",   16'(bus_a.PM_Addr), 16'h08);
        chk("h.re",     16'(bus_a.PM_RE),   16'h0);
        bus_a.Jump = 1'b1; bus_a.JumpAddr = 8'h20;
        step();
        bus_a.Jump = 1'b0;
        chk("h.jump_ign.addr",   16'(bus_a.PM_Addr), 16'h08);
        chk("h.jump_ign.halted", 16'(bus_a.Halted),  16'h1);
        start_a();
        chk("r.halted", 16'(bus_a.Halted),  16'h0);
        chk("r.addr",   16'(bus_a.PM_Addr), 16'h08);
        step();
        chk("r.e1.valid", 16'(bus_a.Ins_Valid), 16'h0);
        step();
        chk_ins("r.t0", 13'h0108, 1'b1, 8'h08);

        // Asynchronous reset mid-run, checked between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_ins("ar", NOP, 1'b0, 8'h00);
        chk("ar.addr",   16'(bus_a.PM_Addr), 16'h00);
        chk("ar.re",     16'(bus_a.PM_RE),   16'h0);
        chk("ar.halted", 16'(bus_a.Halted),  16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Phase 4: PC wrap from reset vector 0xFE
        bus_b.Start = 1'b1;
        step();
        bus_b.Start = 1'b0;
        step();
        step();
        chk("w0.pc",  16'(bus_b.Ins_PC), 16'h00FE);
        chk("w0.ins", 16'(bus_b.Ins),    16'h01FE);
        step();
        chk("w1.pc",  16'(bus_b.Ins_PC), 16'h00FF);
        step();
        chk("w2.pc",  16'(bus_b.Ins_PC), 16'h0000);
        chk("w2.ins", 16'(bus_b.Ins),    16'h0805);
        step();
        chk("w3.pc",    16'(bus_b.Ins_PC),    16'h0001);
        chk("w3.valid", 16'(bus_b.Ins_Valid), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
